noc_rr_arbiter: RTL and testbench

NOC_RR_ARBITER -- requirements
Module: noc_rr_arbiter

---
 rtl/noc_pkg.sv | 13 +
 rtl/rr_priority_picker.sv | 34 +++
 rtl/noc_rr_arbiter.sv | 127 ++++++++++++
 tb/tb_noc_rr_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared types and constants for the NoC round-robin arbiter.
//   arb_state_t : arbitration FSM encoding (idle / locked to a packet owner)
//   FLIT_WIDTH  : default flit payload width in bits
package noc_pkg;

    localparam int unsigned FLIT_WIDTH = 33;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

endpackage : noc_pkg

// File: rtl/rr_priority_picker.sv
// Combinational round-robin find-first.
// Returns the first set bit of req, searching upward from ptr modulo N_IN.
//   req       : request vector
//   ptr       : search start index (must be < N_IN)
//   gnt_valid : at least one request present
//   gnt_idx   : index of the selected request
module rr_priority_picker #(
    parameter int unsigned N_IN = 4
) (
    input  logic [N_IN-1:0]         req,
    input  logic [$clog2(N_IN)-1:0] ptr,
    output logic                    gnt_valid,
    output logic [$clog2(N_IN)-1:0] gnt_idx
);

    localparam int unsigned PW = $clog2(N_IN);

    int unsigned cand;

    // Walk from the farthest offset down to ptr so the nearest match is written last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            cand = (32'(ptr) + 32'(i)) % N_IN;
            if (req[PW'(cand)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = PW'(cand);
            end
        end
    end

endmodule : rr_priority_picker

// File: rtl/noc_rr_arbiter.sv
// Round-robin NoC flit arbiter with packet locking.
// A multi-flit packet holds the output until its tail flit is accepted; the
// round-robin pointer only advances past a winner once its tail is accepted.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/last/data    : per-requester flit inputs (data flattened, requester i at [i*WIDTH +: WIDTH])
//   in_ready              : per-requester accept
//   out_valid/data/last   : registered output flit
//   out_src               : registered index of the requester that sent the flit
//   out_ready             : downstream accept
//   locked                : a multi-flit packet currently owns the output
module noc_rr_arbiter
    import noc_pkg::*;
#(
    parameter int unsigned WIDTH = FLIT_WIDTH,
    parameter int unsigned N_IN  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_IN-1:0]           in_valid,
    input  logic [N_IN-1:0]           in_last,
    input  logic [N_IN*WIDTH-1:0]     in_data,
    output logic [N_IN-1:0]           in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_last,
    output logic [$clog2(N_IN)-1:0]   out_src,
    output logic                      locked
);

    localparam int unsigned PW = $clog2(N_IN);

    arb_state_t     state;
    arb_state_t     stateNext;
    logic [PW-1:0]  owner;
    logic [PW-1:0]  ownerNext;
    logic [PW-1:0]  rrPtr;
    logic [PW-1:0]  rrPtrNext;

    logic           acceptEn;
    logic           gntValid;
    logic [PW-1:0]  gntIdx;
    logic [PW-1:0]  selIdx;
    logic [N_IN-1:0] inReady;
    logic           fire;
    logic [WIDTH-1:0] inFlit [N_IN];

    // Unflatten the payload bus for indexed selection.
    for (genvar g = 0; g < N_IN; g++) begin : g_unpack
        assign inFlit[g] = in_data[g*WIDTH +: WIDTH];
    end

    rr_priority_picker #(
        .N_IN (N_IN)
    ) u_picker (
        .req       (in_valid),
        .ptr       (rrPtr),
        .gnt_valid (gntValid),
        .gnt_idx   (gntIdx)
    );

    // The output register can take a new flit when empty or draining.
    assign acceptEn = !out_valid || out_ready;
    assign in_ready = rst_n ? inReady : '0;
    assign locked   = (state == ARB_LOCKED);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
            owner <= '0;
            rrPtr <= '0;
        end else begin
            state <= stateNext;
            owner <= ownerNext;
            rrPtr <= rrPtrNext;
        end
    end

    // Next-state, grant and pointer update.
    always_comb begin
        stateNext = state;
        ownerNext = owner;
        rrPtrNext = rrPtr;
        inReady   = '0;
        selIdx    = gntIdx;
        fire      = 1'b0;

        if (state == ARB_LOCKED) begin
            selIdx = owner;
            // Owner keeps the grant even while it is idle.
            inReady[owner] = acceptEn;
        end else if (gntValid && acceptEn) begin
            inReady[gntIdx] = 1'b1;
        end

        fire = |(in_valid & inReady);

        if (fire) begin
            if (!in_last[selIdx]) begin
                stateNext = ARB_LOCKED;
                ownerNext = selIdx;
            end else begin
                stateNext = ARB_IDLE;
                rrPtrNext = (32'(selIdx) == N_IN - 1) ? '0 : selIdx + PW'(1);
            end
        end
    end

    // Output flit register; holds while stalled, empties when drained with no new flit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
        end else if (fire) begin
            out_valid <= 1'b1;
            out_data  <= inFlit[selIdx];
            out_last  <= in_last[selIdx];
            out_src   <= selIdx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule : noc_rr_arbiter

// File: tb/tb_noc_rr_arbiter.sv
// Directed self-checking bench for noc_rr_arbiter (4 requesters, 33-bit flits).
module tb_noc_rr_arbiter;

    localparam int unsigned W = 33;
    localparam int unsigned N = 4;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   inValid;
    logic [N-1:0]   inLast;
    logic [N*W-1:0] inData;
    logic [N-1:0]   inReady;
    logic           outValid;
    logic           outReady;
    logic [W-1:0]   outData;
    logic           outLast;
    logic [1:0]     outSrc;
    logic           lockedO;

    int nAsserts;
    int nFail;

    noc_rr_arbiter #(
        .WIDTH (W),
        .N_IN  (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid),
        .in_last   (inLast),
        .in_data   (inData),
        .in_ready  (inReady),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_data  (outData),
        .out_last  (outLast),
        .out_src   (outSrc),
        .locked    (lockedO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setFlit(input int i, input logic [W-1:0] d, input logic last);
        inData[i*W +: W] = d;
        inLast[i]        = last;
    endtask

    task automatic chkOut(input string tag, input logic [W-1:0] d, input logic [1:0] src, input logic last);
        chk({tag, "_valid"}, 64'(outValid), 64'(1'b1));
        chk({tag, "_data"},  64'(outData),  64'(d));
        chk({tag, "_src"},   64'(outSrc),   64'(src));
        chk({tag, "_last"},  64'(outLast),  64'(last));
    endtask

    initial begin
        nAsserts = 0;
        nFail    = 0;
        rst_n    = 1'b0;
        inValid  = '1;
        inLast   = '0;
        inData   = '0;
        outReady = 1'b1;

        // Reset state, in_ready held low even with requests pending
        tick();
        tick();
        chk("rst_out_valid", 64'(outValid), 64'd0);
        chk("rst_out_data",  64'(outData),  64'd0);
        chk("rst_out_src",   64'(outSrc),   64'd0);
        chk("rst_out_last",  64'(outLast),  64'd0);
        chk("rst_locked",    64'(lockedO),  64'd0);
        chk("rst_in_ready",  64'(inReady),  64'd0);
        rst_n = 1'b1;

        // Four single-flit packets presented together -> sources 0,1,2,3 back to back
        inValid = 4'b1111;
        for (int i = 0; i < 4; i++) setFlit(i, W'(8'hA0 + i), 1'b1);
        #1;
        chk("rr_first_ready", 64'(inReady), 64'b0001);
        for (int i = 0; i < 4; i++) begin
            tick();
            chkOut($sformatf("rr_out%0d", i), W'(8'hA0 + i), 2'(i), 1'b1);
            inValid[i] = 1'b0;
        end
        tick();
        chk("rr_drain_valid", 64'(outValid), 64'd0);

        // Requester 2 3-flit packet while requester 0 waits (pointer now 0)
        inValid = 4'b0100;
        setFlit(2, W'(8'h10), 1'b0);
        #1;
        chk("pkt_ready0", 64'(inReady), 64'b0100);
        tick();
        chkOut("pkt_f0", W'(8'h10), 2'd2, 1'b0);
        chk("pkt_locked0", 64'(lockedO), 64'd1);
        inValid = 4'b0101;
        setFlit(0, W'(8'h55), 1'b1);
        setFlit(2, W'(8'h11), 1'b0);
        #1;
        chk("pkt_ready1", 64'(inReady), 64'b0100);
        tick();
        chkOut("pkt_f1", W'(8'h11), 2'd2, 1'b0);
        chk("pkt_locked1", 64'(lockedO), 64'd1);
        setFlit(2, W'(8'h12), 1'b1);
        tick();
        chkOut("pkt_f2", W'(8'h12), 2'd2, 1'b1);
        chk("pkt_unlocked", 64'(lockedO), 64'd0);
        inValid = 4'b0001;
        #1;
        chk("pkt_r0_ready", 64'(inReady), 64'b0001);
        tick();
        chkOut("pkt_r0", W'(8'h55), 2'd0, 1'b1);
        inValid = 4'b0000;

        // Backpressure: 5 stalled cycles hold the output and block all requesters
        outReady = 1'b0;
        inValid  = 4'b0010;
        setFlit(1, W'(8'h77), 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp_ready%0d", i), 64'(inReady), 64'b0000);
            tick();
            chkOut($sformatf("bp_hold%0d", i), W'(8'h55), 2'd0, 1'b1);
        end
        outReady = 1'b1;
        #1;
        chk("bp_release_ready", 64'(inReady), 64'b0010);
        tick();
        chkOut("bp_next", W'(8'h77), 2'd1, 1'b1);
        inValid = 4'b0000;
        tick();
        chk("bp_drain_valid", 64'(outValid), 64'd0);

        // Owner 1 goes idle mid-packet while requester 3 waits (pointer now 2)
        inValid = 4'b0010;
        setFlit(1, W'(8'h21), 1'b0);
        tick();
        chkOut("gap_f0", W'(8'h21), 2'd1, 1'b0);
        inValid = 4'b1000;
        setFlit(3, W'(8'h3F), 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("gap_ready%0d", i), 64'(inReady), 64'b0010);
            tick();
            chk($sformatf("gap_valid%0d", i), 64'(outValid), 64'd0);
            chk($sformatf("gap_locked%0d", i), 64'(lockedO), 64'd1);
        end
        inValid = 4'b1010;
        setFlit(1, W'(8'h22), 1'b1);
        #1;
        chk("gap_tail_ready", 64'(inReady), 64'b0010);
        tick();
        chkOut("gap_tail", W'(8'h22), 2'd1, 1'b1);
        chk("gap_unlocked", 64'(lockedO), 64'd0);
        inValid = 4'b1000;
        tick();
        chkOut("gap_r3", W'(8'h3F), 2'd3, 1'b1);
        inValid = 4'b0000;

        // Reset mid-packet from requester 1, then requester 0 wins (pointer was 0)
        inValid = 4'b0010;
        setFlit(1, W'(8'h31), 1'b0);
        tick();
        chkOut("mrst_f0", W'(8'h31), 2'd1, 1'b0);
        inValid = 4'b0011;
        setFlit(0, W'(8'h40), 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid",  64'(outValid), 64'd0);
        chk("mrst_data",   64'(outData),  64'd0);
        chk("mrst_src",    64'(outSrc),   64'd0);
        chk("mrst_locked", 64'(lockedO),  64'd0);
        chk("mrst_ready",  64'(inReady),  64'd0);
        rst_n = 1'b1;
        #1;
        chk("mrst_after_ready", 64'(inReady), 64'b0001);
        tick();
        chkOut("mrst_r0", W'(8'h40), 2'd0, 1'b1);
        inValid = 4'b0000;
        tick();

        // Requester 3 streams 100 single-flit packets at full rate
        inValid = 4'b1000;
        for (int k = 0; k < 100; k++) begin
            setFlit(3, W'(16'h0100 + k), 1'b1);
            #1;
            chk($sformatf("strm_ready%0d", k), 64'(inReady), 64'b1000);
            tick();
            chkOut($sformatf("strm%0d", k), W'(16'h0100 + k), 2'd3, 1'b1);
        end
        inValid = 4'b0000;
        tick();
        chk("strm_drain_valid", 64'(outValid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule : tb_noc_rr_arbiter
